conv1_ctrl: RTL and testbench

Sequencer for the LeNet first convolution layer. It scans a 5×5 window over the 32×32 input image, issuing image and weight read addresses and MAC clear/accumulate strobes. After the pipeline drains through the six bias/activation units, it generates write enables and addresses for the six 28×28 f2 feature-map buffers. One controller drives all six channels in lockstep; the channels share addresses and strobes and differ only in weights and bias.

---
 rtl/conv1_pkg.sv | 37 +++
 rtl/conv1_addr_gen.sv | 82 ++++++++
 rtl/conv1_ctrl.sv | 149 ++++++++++++++
 tb/tb_conv1_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// conv1_pkg: constants and types shared by the LeNet conv1 sequencer.
//   IMG_W/K/OUT_W/TAPS/NPIX : default layer geometry (32x32 image, 5x5 kernel)
//   ADDR_W/TAP_W            : widths of the image/f2 and weight address buses
//   state_t                 : sequencer FSM states
//   tap_t                   : one issued tap travelling down the read-latency pipe
//   wr_t                    : one pending f2 write travelling down the MAC/activation pipe
package conv1_pkg;

   localparam int IMG_W = 32;
   localparam int K     = 5;
   localparam int OUT_W = IMG_W - K + 1;
   localparam int TAPS  = K * K;
   localparam int NPIX  = OUT_W * OUT_W;

   localparam int ADDR_W = 10;
   localparam int TAP_W  = 5;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic              valid;
      logic              first;
      logic              last;
      logic [ADDR_W-1:0] pix;
   } tap_t;

   typedef struct packed {
      logic              wen;
      logic [ADDR_W-1:0] pix;
   } wr_t;

endpackage

// File: rtl/conv1_addr_gen.sv
// conv1_addr_gen: window scanner for the conv1 layer.
// Four nested counters (kx innermost, then ky, ox, oy) walk every tap of every
// output pixel, one tap per step. All outputs are combinational from the counters.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : hold all counters at zero (used whenever no pass is issuing)
//   step       : advance to the next tap
//   img_raddr  : (oy+ky)*IMG_W + (ox+kx)
//   w_raddr    : ky*K + kx
//   pix        : oy*OUT_W + ox
//   first      : current tap is tap 0 of its pixel
//   last       : current tap is the final tap of its pixel
//   end_pass   : current tap is the final tap of the final pixel
module conv1_addr_gen
   import conv1_pkg::*;
#(
   parameter int IMG_W = conv1_pkg::IMG_W,
   parameter int K     = conv1_pkg::K
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              step,
   output logic [ADDR_W-1:0] img_raddr,
   output logic [TAP_W-1:0]  w_raddr,
   output logic [ADDR_W-1:0] pix,
   output logic              first,
   output logic              last,
   output logic              end_pass
);

   localparam int OW   = IMG_W - K + 1;
   localparam int KC_W = $clog2(K);
   localparam int OC_W = $clog2(OW);

   localparam logic [KC_W-1:0] K_MAX = KC_W'(K - 1);
   localparam logic [OC_W-1:0] O_MAX = OC_W'(OW - 1);

   logic [KC_W-1:0] kx_q;
   logic [KC_W-1:0] ky_q;
   logic [OC_W-1:0] ox_q;
   logic [OC_W-1:0] oy_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         kx_q <= '0;
         ky_q <= '0;
         ox_q <= '0;
         oy_q <= '0;
      end else if (step) begin
         if (kx_q != K_MAX) begin
            kx_q <= kx_q + KC_W'(1);
         end else begin
            kx_q <= '0;
            if (ky_q != K_MAX) begin
               ky_q <= ky_q + KC_W'(1);
            end else begin
               ky_q <= '0;
               if (ox_q != O_MAX) begin
                  ox_q <= ox_q + OC_W'(1);
               end else begin
                  ox_q <= '0;
                  // oy wraps too, so the counters are back at zero after a full pass
                  oy_q <= (oy_q == O_MAX) ? '0 : oy_q + OC_W'(1);
               end
            end
         end
      end
   end

   // Largest image address is (OW-1+K-1)*IMG_W + (OW-1+K-1) = 1023 for the
   // default geometry, so ADDR_W arithmetic never wraps.
   assign img_raddr = (ADDR_W'(oy_q) + ADDR_W'(ky_q)) * ADDR_W'(IMG_W)
                    + ADDR_W'(ox_q) + ADDR_W'(kx_q);
   assign w_raddr   = TAP_W'(ky_q) * TAP_W'(K) + TAP_W'(kx_q);
   assign pix       = ADDR_W'(oy_q) * ADDR_W'(OW) + ADDR_W'(ox_q);

   assign first    = (kx_q == '0) && (ky_q == '0);
   assign last     = (kx_q == K_MAX) && (ky_q == K_MAX);
   assign end_pass = last && (ox_q == O_MAX) && (oy_q == O_MAX);

endmodule

// File: rtl/conv1_ctrl.sv
// conv1_ctrl: sequencer for the LeNet first convolution layer.
// Scans a KxK window over the IMG_W x IMG_W image, issuing image/weight reads
// and MAC strobes, then writes the six OUT_W x OUT_W f2 maps in lockstep once
// each pixel has drained through the MAC and bias/activation stages.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (wins over start)
//   start      : one-cycle pass request
//   busy       : a pass is issuing or draining
//   done       : one-cycle pulse after the final f2 write
//   img_rden   : image read enable (one tap per cycle while issuing)
//   img_raddr  : image read address
//   w_raddr    : weight tap index 0..K*K-1
//   mac_en     : MAC accumulate strobe (read data valid)
//   mac_clr    : MAC load instead of add (tap 0)
//   f2_wen     : f2 write enable for all six maps
//   f2_waddr   : f2 write address 0..OUT_W*OUT_W-1
//
// Start handshake: start is a request sampled on the clock edge and is
// accepted only when the sequencer is not busy (IDLE, or the DONE cycle that
// ends the previous pass). A start seen while busy is dropped, never queued.
// Acceptance is visible as busy=1 in the following cycle.
module conv1_ctrl
   import conv1_pkg::*;
#(
   parameter int IMG_W    = conv1_pkg::IMG_W,
   parameter int K        = conv1_pkg::K,
   parameter int RD_LAT   = 1,
   parameter int MAC_LAT  = 1,
   parameter int EXEC_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              img_rden,
   output logic [ADDR_W-1:0] img_raddr,
   output logic [TAP_W-1:0]  w_raddr,
   output logic              mac_en,
   output logic              mac_clr,
   output logic              f2_wen,
   output logic [ADDR_W-1:0] f2_waddr
);

   localparam int W_LAT = MAC_LAT + EXEC_LAT;
   localparam int D     = RD_LAT + W_LAT;
   localparam int DW    = $clog2(D + 1);

   localparam logic [DW-1:0] DRAIN_LAST = DW'(D - 1);

   state_t          state_q;
   state_t          state_d;
   logic [DW-1:0]   drain_q;
   logic            run;

   logic [ADDR_W-1:0] ag_raddr;
   logic [TAP_W-1:0]  ag_waddr;
   logic [ADDR_W-1:0] ag_pix;
   logic              ag_first;
   logic              ag_last;
   logic              ag_end;

   tap_t rd_q [RD_LAT];
   wr_t  wr_q [W_LAT];
   tap_t issue;
   wr_t  wr_in;

   assign run = (state_q == RUN);

   conv1_addr_gen #(
      .IMG_W (IMG_W),
      .K     (K)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .clear     (!run),
      .step      (run),
      .img_raddr (ag_raddr),
      .w_raddr   (ag_waddr),
      .pix       (ag_pix),
      .first     (ag_first),
      .last      (ag_last),
      .end_pass  (ag_end)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= (state_q == DRAIN) ? drain_q + DW'(1) : '0;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (ag_end) state_d = DRAIN;
         DRAIN:   if (drain_q == DRAIN_LAST) state_d = DONE;
         // DONE is not busy, so a start here chains straight into the next pass
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------- pipelines
   always_comb begin
      issue       = '0;
      issue.valid = run;
      issue.first = run && ag_first;
      issue.last  = run && ag_last;
      issue.pix   = run ? ag_pix : '0;
   end

   // Only the last tap of a pixel turns into a write; its pixel index rides along.
   always_comb begin
      wr_in     = '0;
      wr_in.wen = rd_q[RD_LAT-1].valid && rd_q[RD_LAT-1].last;
      wr_in.pix = wr_in.wen ? rd_q[RD_LAT-1].pix : '0;
   end

   // Clearing every stage on reset guarantees no stale write escapes an aborted pass.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) rd_q[i] <= '0;
         for (int i = 0; i < W_LAT; i++)  wr_q[i] <= '0;
      end else begin
         rd_q[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) rd_q[i] <= rd_q[i-1];
         wr_q[0] <= wr_in;
         for (int i = 1; i < W_LAT; i++)  wr_q[i] <= wr_q[i-1];
      end
   end

   // ------------------------------------------------------------ outputs
   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign img_rden  = run;
   assign img_raddr = run ? ag_raddr : '0;
   assign w_raddr   = run ? ag_waddr : '0;
   assign mac_en    = rd_q[RD_LAT-1].valid;
   assign mac_clr   = rd_q[RD_LAT-1].valid && rd_q[RD_LAT-1].first;
   assign f2_wen    = wr_q[W_LAT-1].wen;
   assign f2_waddr  = wr_q[W_LAT-1].pix;

endmodule

// File: tb/tb_conv1_ctrl.sv
// tb_conv1_ctrl: bench for conv1_ctrl. Two instances share clk/rst/start:
// dut_a with default latencies (D=3) and dut_b with RD_LAT=2, MAC_LAT=3 (D=6).
// Every cycle both are compared with a closed-form reference that derives all
// outputs from the number of cycles since the pass began.
module tb_conv1_ctrl;
   import conv1_pkg::*;

   localparam int LAST_ISSUE = NPIX * TAPS;   // 19600

   logic clk = 1'b0;
   logic rst;
   logic start;

   always #5 clk = ~clk;

   logic              busy_a, done_a, img_rden_a, mac_en_a, mac_clr_a, f2_wen_a;
   logic [ADDR_W-1:0] img_raddr_a, f2_waddr_a;
   logic [TAP_W-1:0]  w_raddr_a;
   logic              busy_b, done_b, img_rden_b, mac_en_b, mac_clr_b, f2_wen_b;
   logic [ADDR_W-1:0] img_raddr_b, f2_waddr_b;
   logic [TAP_W-1:0]  w_raddr_b;

   conv1_ctrl dut_a (
      .clk (clk), .rst (rst), .start (start),
      .busy (busy_a), .done (done_a), .img_rden (img_rden_a),
      .img_raddr (img_raddr_a), .w_raddr (w_raddr_a),
      .mac_en (mac_en_a), .mac_clr (mac_clr_a),
      .f2_wen (f2_wen_a), .f2_waddr (f2_waddr_a)
   );

   conv1_ctrl #(.RD_LAT(2), .MAC_LAT(3), .EXEC_LAT(1)) dut_b (
      .clk (clk), .rst (rst), .start (start),
      .busy (busy_b), .done (done_b), .img_rden (img_rden_b),
      .img_raddr (img_raddr_b), .w_raddr (w_raddr_b),
      .mac_en (mac_en_b), .mac_clr (mac_clr_b),
      .f2_wen (f2_wen_b), .f2_waddr (f2_waddr_b)
   );

   logic [30:0] obs_a, obs_b;
   assign obs_a = {busy_a, done_a, img_rden_a, img_raddr_a, w_raddr_a,
                   mac_en_a, mac_clr_a, f2_wen_a, f2_waddr_a};
   assign obs_b = {busy_b, done_b, img_rden_b, img_raddr_b, w_raddr_b,
                   mac_en_b, mac_clr_b, f2_wen_b, f2_waddr_b};

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int rel    = 0;
   int n_m [2];
   int rl_m [2] = '{1, 2};
   int d_m  [2] = '{3, 6};
   int wen_cnt, max_ra, done_cnt;

   int seq_tab [25] = '{0, 1, 2, 3, 4, 32, 33, 34, 35, 36, 64, 65, 66, 67, 68,
                        96, 97, 98, 99, 100, 128, 129, 130, 131, 132};

   // Reference: n = cycles since the start was sampled (n=1 is the first issue),
   // n < 1 means no pass in flight.
   function automatic logic [30:0] model_out(int n, int rl, int d);
      logic busy, done, rden, men, mclr, wen;
      logic [9:0] ra, wa;
      logic [4:0] wr;
      int k, p, t;
      busy = 0; done = 0; rden = 0; men = 0; mclr = 0; wen = 0;
      ra = '0; wa = '0; wr = '0;
      if (n >= 1) begin
         busy = (n <= LAST_ISSUE + d);
         done = (n == LAST_ISSUE + 1 + d);
         if (n <= LAST_ISSUE) begin
            k = n - 1;
            p = k / TAPS;
            t = k % TAPS;
            rden = 1;
            ra = 10'(((p / OUT_W) + (t / K)) * IMG_W + (p % OUT_W) + (t % K));
            wr = 5'(t);
         end
         if (n >= 1 + rl && n <= LAST_ISSUE + rl) begin
            men  = 1;
            mclr = ((n - 1 - rl) % TAPS == 0);
         end
         if (n >= 1 + d && n <= LAST_ISSUE + d && (n - 1 - d) % TAPS == TAPS - 1) begin
            wen = 1;
            wa  = 10'((n - 1 - d) / TAPS);
         end
      end
      return {busy, done, rden, ra, wr, men, mclr, wen, wa};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic stats_clear();
      wen_cnt  = 0;
      max_ra   = 0;
      done_cnt = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst)
            n_m[i] = -1;
         else if (start && (n_m[i] < 1 || n_m[i] == LAST_ISSUE + 1 + d_m[i]))
            n_m[i] = 1;
         else if (n_m[i] >= 1) begin
            n_m[i]++;
            if (n_m[i] > LAST_ISSUE + 1 + d_m[i]) n_m[i] = -1;
         end
      end
      #1;
      cyc++;
      rel++;
      check("dut_a_outputs", 32'(obs_a), 32'(model_out(n_m[0], rl_m[0], d_m[0])));
      check("dut_b_outputs", 32'(obs_b), 32'(model_out(n_m[1], rl_m[1], d_m[1])));
      if (f2_wen_a) begin
         check("wen_order", 32'(f2_waddr_a), 32'(wen_cnt));
         wen_cnt++;
      end
      if (img_rden_a && int'(img_raddr_a) > max_ra) max_ra = int'(img_raddr_a);
      if (done_a) done_cnt++;
   endtask

   task automatic run_to(input int target);
      while (rel < target) tick();
   endtask

   // Cycles 1..26 of a pass with hard-coded expectations.
   task automatic first_seq();
      for (int i = 0; i < 25; i++) begin
         check("seq_raddr", 32'(img_raddr_a), 32'(seq_tab[i]));
         check("seq_waddr", 32'(w_raddr_a), 32'(i));
         if (i == 1) check("mac_clr_a", 32'(mac_clr_a), 32'd1);
         if (i == 2) check("mac_clr_b", 32'(mac_clr_b), 32'd1);
         tick();
      end
      check("wrap_raddr", 32'(img_raddr_a), 32'd1);
   endtask

   task automatic run_pass_random(input int target, input int pulse_at);
      while (rel < target) begin
         start = (rel == pulse_at) ||
                 (rel >= 2 && rel < LAST_ISSUE - 10 && $urandom_range(0, 499) == 0);
         tick();
      end
      start = 1'b0;
   endtask

   initial begin
      int seen;
      n_m[0] = -1;
      n_m[1] = -1;
      stats_clear();
      rst   = 1'b1;
      start = 1'b1;        // rst wins over start
      tick();
      start = 1'b0;
      tick();
      check("reset_a", 32'(obs_a), 32'd0);
      check("reset_b", 32'(obs_b), 32'd0);
      rst = 1'b0;
      tick();

      // Pass 1: directed opening, then reset in cycle 500.
      rel = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_c1", 32'(busy_a), 32'd1);
      first_seq();
      run_to(28);
      check("first_wen_a", 32'({f2_wen_a, f2_waddr_a}), 32'({1'b1, 10'd0}));
      run_to(31);
      check("first_wen_b", 32'({f2_wen_b, f2_waddr_b}), 32'({1'b1, 10'd0}));
      run_to(500);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun_rst_a", 32'(obs_a), 32'd0);
      check("midrun_rst_b", 32'(obs_b), 32'd0);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (f2_wen_a || f2_wen_b) seen++;
      end
      check("no_wen_after_rst", 32'(seen), 32'd0);

      // Pass 2: full pass, start at 100 ignored, back-to-back start at 19604.
      repeat ($urandom_range(1, 5)) tick();
      stats_clear();
      rel = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      first_seq();
      run_to(701);
      check("row_wrap_raddr", 32'({img_raddr_a, w_raddr_a}), 32'({10'd32, 5'd0}));
      run_to(728);
      check("row_wrap_wen", 32'({f2_wen_a, f2_waddr_a}), 32'({1'b1, 10'd28}));
      run_pass_random(19604, 100);
      check("done_a", 32'({done_a, busy_a}), 32'({1'b1, 1'b0}));
      check("wen_count", 32'(wen_cnt), 32'(NPIX));
      check("max_raddr", 32'(max_ra), 32'd1023);
      check("done_count", 32'(done_cnt), 32'd1);
      stats_clear();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_issue", 32'({busy_a, img_rden_a, img_raddr_a}), 32'({1'b1, 1'b1, 10'd0}));
      run_to(19607);
      check("done_b", 32'({done_b, busy_b}), 32'({1'b1, 1'b0}));

      // Pass 3 (dut_a only): aborted at a random point.
      repeat ($urandom_range(30, 3000)) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_rst_a", 32'(obs_a), 32'd0);
      check("abort_rst_b", 32'(obs_b), 32'd0);

      // Pass 4: full pass with random spurious starts.
      repeat ($urandom_range(1, 5)) tick();
      stats_clear();
      rel = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      run_pass_random(19612, -1);
      check("wen_count_2", 32'(wen_cnt), 32'(NPIX));
      check("done_count_2", 32'(done_cnt), 32'd1);
      check("idle_end", 32'({busy_a, busy_b}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
